output_stream_buffer: RTL and testbench

Downstream stage of the convolution controller FSM. Captures each finished output pixel (accumulator value plus x/y/output-channel coordinates) on the controller's `output_valid` pulse. Buffers it in a small first-word-fall-through FIFO and streams it off-chip over a valid/ready handshake. Signals back-pressure to the controller through `stall` and reports overflow and end-of-layer completion.

---
 rtl/output_stream_buffer.sv | 128 ++++++++++++
 tb/tb_output_stream_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_stream_buffer.sv
// Output pixel FIFO between the convolution controller and the off-chip stream.
// First-word-fall-through circular buffer with stall, sticky overflow and end-of-layer done.
module output_stream_buffer #(
  parameter int ACC_WIDTH    = 32,
  parameter int COORD_WIDTH  = 32,
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [ACC_WIDTH-1:0]     in_data,
  input  logic [COORD_WIDTH-1:0]   in_x,
  input  logic [COORD_WIDTH-1:0]   in_y,
  input  logic [COORD_WIDTH-1:0]   in_ch,
  input  logic                     in_last,
  output logic                     stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_data,
  output logic [COORD_WIDTH-1:0]   out_x,
  output logic [COORD_WIDTH-1:0]   out_y,
  output logic [COORD_WIDTH-1:0]   out_ch,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(STALL_MARGIN);

  typedef enum logic {ST_STREAM, ST_DONE} state_e;

  typedef struct packed {
    logic [ACC_WIDTH-1:0]   data;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] ch;
    logic                   last;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         head;
  entry_t         in_entry;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           overflow_q, overflow_d;
  state_e         state_q, state_d;
  logic           full, push, pop, wr_en;

  always_comb begin
    in_entry = '{data: in_data, x: in_x, y: in_y, ch: in_ch, last: in_last};
    head     = mem_q[rd_ptr_q];
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    full       = (level_q == DEPTH_L);
    pop        = out_valid && out_ready;
    push       = in_valid && (!full || pop);
    wr_en      = push && !clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      state_d    = ST_STREAM;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (in_valid && !push) overflow_d = 1'b1;
      if (pop && head.last)  state_d = ST_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_STREAM;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // NOTE: storage is reset so the FWFT head reads zero out of reset; the array is small enough to afford it.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_comb begin
    out_valid = (level_q != '0);
    stall     = ((DEPTH_L - level_q) <= MARGIN_L);
    level     = level_q;
    overflow  = overflow_q;
    done      = (state_q == ST_DONE);
    out_data  = head.data;
    out_x     = head.x;
    out_y     = head.y;
    out_ch    = head.ch;
    out_last  = head.last;
  end

endmodule

// File: tb/tb_output_stream_buffer.sv
// Bench for output_stream_buffer: vector table, corner-case sequences, and a
// randomized run against a queue-based reference model.
module tb_output_stream_buffer;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;

  logic        clk;
  logic        arst_n_in;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data, in_x, in_y, in_ch;
  logic        in_last;
  logic        stall, out_valid, out_ready;
  logic [31:0] out_data, out_x, out_y, out_ch;
  logic        out_last;
  logic [2:0]  level;
  logic        overflow, done;

  int total = 0;
  int bad   = 0;

  output_stream_buffer #(
    .ACC_WIDTH(32), .COORD_WIDTH(32), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .in_last(in_last),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .out_last(out_last), .level(level), .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: apply inputs, take one rising edge, return at the next negedge.
  task automatic drive(input logic iv, input logic [31:0] d, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ch, input logic last,
                       input logic rdy, input logic clr);
    in_valid  = iv;
    in_data   = d;
    in_x      = x;
    in_y      = y;
    in_ch     = ch;
    in_last   = last;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    int          lvl;
    logic        ov;
    logic [31:0] head;
    logic        stl;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] data, x, y, ch;
    logic        last;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic m_ovf, m_done;

  task automatic check_model(input string tag);
    check({tag, "_level"}, 64'(level), 64'(mq.size()));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({tag, "_stall"}, 64'(stall), 64'((DEPTH - mq.size()) <= MARGIN));
    check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, "_done"}, 64'(done), 64'(m_done));
    if (mq.size() != 0) begin
      check({tag, "_head"}, {out_data, out_x}, {mq[0].data, mq[0].x});
      check({tag, "_head_yc"}, {out_y, out_ch[30:0], out_last},
            {mq[0].y, mq[0].ch[30:0], mq[0].last});
    end
  endtask

  initial begin
    arst_n_in = 1'b0;
    clear = 1'b0; in_valid = 1'b0; in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
    in_last = 1'b0; out_ready = 1'b0;

    // Fill/stall then full push+pop; expected values are post-edge state.
    vecs.push_back('{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b1, 32'h11, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h22, 1'b0, 1'b0, 2, 1'b1, 32'h11, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h33, 1'b0, 1'b0, 3, 1'b1, 32'h11, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h44, 1'b0, 1'b0, 4, 1'b1, 32'h11, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h55, 1'b0, 1'b0, 4, 1'b1, 32'h11, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 3, 1'b1, 32'h22, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 32'h33, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h44, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 32'h00, 1'b0, 1'b1, 0, 1'b0, 32'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h61, 1'b0, 1'b0, 1, 1'b1, 32'h61, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h62, 1'b0, 1'b0, 2, 1'b1, 32'h61, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h63, 1'b0, 1'b0, 3, 1'b1, 32'h61, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h64, 1'b0, 1'b0, 4, 1'b1, 32'h61, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'h65, 1'b1, 1'b0, 4, 1'b1, 32'h62, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 3, 1'b1, 32'h63, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 32'h64, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h65, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b0});

    // Reset values while reset is held.
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_data", {out_data, out_x}, 64'd0);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);

    // Single entry.
    drive(1'b1, 32'h1234, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, 1'b0);
    check("single_level1", 64'(level), 64'd1);
    check("single_valid1", 64'(out_valid), 64'd1);
    check("single_fields", {out_data, out_x}, {32'h1234, 32'd2});
    check("single_fields2", {out_y, out_ch[30:0], out_last}, {32'd3, 31'd5, 1'b0});
    idle(1'b1);
    check("single_level0", 64'(level), 64'd0);
    check("single_valid0", 64'(out_valid), 64'd0);

    // Vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].data, 32'(i), 32'(i + 1), 32'(i + 2), 1'b0,
            vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].lvl));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].stl));
      check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      if (vecs[i].ov) check($sformatf("vec%0d_head", i), 64'(out_data), 64'(vecs[i].head));
    end

    // Back-pressure hold.
    drive(1'b1, 32'd7, 32'd8, 32'd9, 32'd10, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      idle(1'b0);
      check($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_fields", c), {out_data, out_x}, {32'd7, 32'd8});
      check($sformatf("hold%0d_fields2", c), {out_y, out_ch}, {32'd9, 32'd10});
    end
    idle(1'b1);
    check("hold_popped", 64'(out_valid), 64'd0);

    // Completion, then overflow, then clear.
    drive(1'b1, 32'hA1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hA3, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("done_pop1", 64'(done), 64'd0);
    idle(1'b1);
    check("done_pop2", 64'(done), 64'd0);
    check("done_head_last", 64'(out_last), 64'd1);
    idle(1'b1);
    check("done_pop3", 64'(done), 64'd1);
    idle(1'b0);
    check("done_held", 64'(done), 64'd1);
    for (int k = 0; k < 5; k++) drive(1'b1, 32'(k), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("done_ovf_set", 64'(overflow), 64'd1);
    check("done_ovf_level", 64'(level), 64'd4);
    check("done_still", 64'(done), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("clear_done", 64'(done), 64'd0);
    check("clear_ovf", 64'(overflow), 64'd0);
    check("clear_level", 64'(level), 64'd0);

    // Reset mid-stream with done set and two entries queued.
    drive(1'b1, 32'hB0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    drive(1'b1, 32'hB1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_done", 64'(done), 64'd1);
    check("pre_rst_level", 64'(level), 64'd2);
    in_valid = 1'b0;
    #2 arst_n_in = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    #1 arst_n_in = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h1234, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, 1'b0);
    check("post_rst_level1", 64'(level), 64'd1);
    check("post_rst_fields", {out_data, out_x}, {32'h1234, 32'd2});
    idle(1'b1);
    check("post_rst_level0", 64'(level), 64'd0);

    // Randomized run against the queue model.
    mq.delete();
    m_ovf = 1'b0;
    m_done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic iv, rdy, clr, pop_m, full_m;
      ent_t e;
      iv  = ($urandom_range(99) < 60);
      rdy = ($urandom_range(99) < 50);
      clr = ($urandom_range(63) == 0);
      e.data = $urandom; e.x = $urandom; e.y = $urandom; e.ch = $urandom;
      e.last = ($urandom_range(7) == 0);
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
        m_done = 1'b0;
      end else begin
        pop_m  = (mq.size() != 0) && rdy;
        full_m = (mq.size() == DEPTH);
        if (pop_m) begin
          if (mq[0].last) m_done = 1'b1;
          void'(mq.pop_front());
        end
        if (iv) begin
          if (!full_m || pop_m) mq.push_back(e);
          else m_ovf = 1'b1;
        end
      end
      drive(iv, e.data, e.x, e.y, e.ch, e.last, rdy, clr);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
